// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: 2-bit counter encodings, the default PHT
// index width, the saturating update helper and the update-controller FSM states.
package bp_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam int PHT_AW_DEF = 10;

    typedef logic [0:0] bp_state_t;
    localparam bp_state_t S_INIT = 1'b0;
    localparam bp_state_t S_RUN  = 1'b1;

    function automatic logic [1:0] sat(input logic [1:0] c, input logic taken);
        logic [1:0] r;
        r = c;
        if (taken) begin
            if (c != ST) r = c + 2'd1;
        end else begin
            if (c != SNT) r = c - 2'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// Pending-update queue: two pushes (port 0 first) and one pop per cycle,
// with a flush that empties it in one cycle.
module bp_update_fifo
    import bp_pkg::*;
#(
    parameter int W     = 11,
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          flush,
    input  logic          push0,
    input  logic [W-1:0]  push0_data,
    input  logic          push1,
    input  logic [W-1:0]  push1_data,
    input  logic          pop,
    output logic [W-1:0]  head_data,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem_reg [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [PW-1:0] slot1;
    logic [CW-1:0] count_next;

    // Port 1 lands behind port 0 when both push in the same cycle.
    assign slot1      = wr_ptr_reg + PW'(push0);
    assign count_next = count_reg + CW'(push0) + CW'(push1) - CW'(pop);

    always_ff @(posedge clk) begin
        if (push0) mem_reg[wr_ptr_reg] <= push0_data;
        if (push1) mem_reg[slot1]      <= push1_data;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            rd_ptr_reg <= wr_ptr_reg;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + PW'(push0) + PW'(push1);
            rd_ptr_reg <= rd_ptr_reg + PW'(pop);
            count_reg  <= count_next;
        end
    end

    assign head_data = mem_reg[rd_ptr_reg];
    assign count     = count_reg;

endmodule

// File: rtl/pht_update_ctrl.sv
// PHT update controller: sweeps the table to INIT_VAL after reset, then queues
// resolved-branch updates and applies them as read-modify-write saturating counts.
module pht_update_ctrl
    import bp_pkg::*;
#(
    parameter int         PHT_AW     = PHT_AW_DEF,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [1:0] INIT_VAL   = WNT
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            stall,
    input  logic                            flush,
    input  logic                            req0_valid,
    input  logic [PHT_AW-1:0]               req0_addr,
    input  logic                            req0_taken,
    input  logic                            req1_valid,
    input  logic [PHT_AW-1:0]               req1_addr,
    input  logic                            req1_taken,
    output logic                            req0_ready,
    output logic                            req1_ready,
    output logic [PHT_AW-1:0]               pht_raddr,
    input  logic [1:0]                      pht_rdata,
    output logic                            pht_we,
    output logic [PHT_AW-1:0]               pht_waddr,
    output logic [1:0]                      pht_wdata,
    output logic                            init_done,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = PHT_AW + 1;

    bp_state_t         state_reg;
    logic [PHT_AW-1:0] idx_reg;
    logic              init_done_reg;

    logic              run;
    logic              in_init;
    logic              acc0;
    logic              acc1;
    logic              pop;
    logic [EW-1:0]     head_data;
    logic [PHT_AW-1:0] head_addr;
    logic              head_taken;
    logic [CW:0]       cnt_ext;

    assign run     = resetn && (state_reg == S_RUN);
    assign in_init = resetn && (state_reg == S_INIT);
    assign cnt_ext = {1'b0, fifo_count};

    // Space is judged on the registered count only; a same-cycle pop does not help.
    assign req0_ready = run && !flush && (cnt_ext < (CW+1)'(FIFO_DEPTH));
    assign acc0       = req0_valid && req0_ready;
    assign req1_ready = run && !flush && ((cnt_ext + (CW+1)'(acc0)) < (CW+1)'(FIFO_DEPTH));
    assign acc1       = req1_valid && req1_ready;

    assign pop        = run && !stall && (fifo_count != '0);
    assign head_addr  = head_data[EW-1:1];
    assign head_taken = head_data[0];
    assign pht_raddr  = head_addr;

    always_comb begin
        pht_we    = 1'b0;
        pht_waddr = head_addr;
        pht_wdata = sat(pht_rdata, head_taken);
        if (in_init) begin
            pht_we    = 1'b1;
            pht_waddr = idx_reg;
            pht_wdata = INIT_VAL;
        end else if (pop) begin
            pht_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg     <= S_INIT;
            idx_reg       <= '0;
            init_done_reg <= 1'b0;
        end else if (state_reg == S_INIT) begin
            idx_reg <= idx_reg + 1'b1;
            if (idx_reg == {PHT_AW{1'b1}}) begin
                state_reg     <= S_RUN;
                init_done_reg <= 1'b1;
            end
        end
    end

    assign init_done = init_done_reg;

    bp_update_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush && run),
        .push0      (acc0),
        .push0_data ({req0_addr, req0_taken}),
        .push1      (acc1),
        .push1_data ({req1_addr, req1_taken}),
        .pop        (pop),
        .head_data  (head_data),
        .count      (fifo_count)
    );

endmodule

// File: tb/tb_pht_update_ctrl.sv
// Directed bench for pht_update_ctrl (PHT_AW=4, FIFO_DEPTH=4) with a small
// behavioural PHT memory behind the asynchronous read port.
module tb_pht_update_ctrl;

    localparam int AW    = 4;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          stall;
    logic          flush;
    logic          req0_valid;
    logic [AW-1:0] req0_addr;
    logic          req0_taken;
    logic          req1_valid;
    logic [AW-1:0] req1_addr;
    logic          req1_taken;
    logic          req0_ready;
    logic          req1_ready;
    logic [AW-1:0] pht_raddr;
    logic [1:0]    pht_rdata;
    logic          pht_we;
    logic [AW-1:0] pht_waddr;
    logic [1:0]    pht_wdata;
    logic          init_done;
    logic [2:0]    fifo_count;

    logic [1:0] pht_mem [16];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign pht_rdata = pht_mem[pht_raddr];
    always @(posedge clk) if (pht_we) pht_mem[pht_waddr] <= pht_wdata;

    pht_update_ctrl #(
        .PHT_AW     (AW),
        .FIFO_DEPTH (DEPTH),
        .INIT_VAL   (2'b01)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .stall      (stall),
        .flush      (flush),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_taken (req0_taken),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_taken (req1_taken),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .pht_raddr  (pht_raddr),
        .pht_rdata  (pht_rdata),
        .pht_we     (pht_we),
        .pht_waddr  (pht_waddr),
        .pht_wdata  (pht_wdata),
        .init_done  (init_done),
        .fifo_count (fifo_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic v0, input int a0, input logic t0,
                           input logic v1, input int a1, input logic t1);
        req0_valid = v0; req0_addr = AW'(a0); req0_taken = t0;
        req1_valid = v1; req1_addr = AW'(a1); req1_taken = t1;
    endtask

    // Next cycle: drive on the falling edge, sample combinational outputs 1 ns later.
    task automatic next_cyc();
        @(negedge clk);
    endtask

    task automatic expect_write(input string tag, input int addr, input int data);
        check({tag, ".we"},    pht_we,    1);
        check({tag, ".waddr"}, pht_waddr, addr);
        check({tag, ".wdata"}, pht_wdata, data);
        $display("txn %s: write addr=%0d data=%0d", tag, pht_waddr, pht_wdata);
    endtask

    // One update through an otherwise idle queue: accept, then observe its write.
    task automatic single_update(input string tag, input int addr, input logic taken, input int exp);
        next_cyc();
        set_req(1'b1, addr, taken, 1'b0, 0, 1'b0);
        #1 check({tag, ".rdy0"}, req0_ready, 1);
        next_cyc();
        set_req(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
        #1 expect_write(tag, addr, exp);
    endtask

    task automatic run_sweep(input string tag);
        for (int i = 0; i < 16; i++) begin
            #1;
            check($sformatf("%s.we[%0d]", tag, i),    pht_we,     1);
            check($sformatf("%s.waddr[%0d]", tag, i), pht_waddr,  i);
            check($sformatf("%s.wdata[%0d]", tag, i), pht_wdata,  1);
            check($sformatf("%s.done[%0d]", tag, i),  init_done,  0);
            check($sformatf("%s.rdy[%0d]", tag, i),   {req0_ready, req1_ready}, 0);
            next_cyc();
        end
        #1;
        check({tag, ".init_done"}, init_done,  1);
        check({tag, ".count"},     fifo_count, 0);
        check({tag, ".we_idle"},   pht_we,     0);
        $display("txn %s: init sweep complete", tag);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) pht_mem[i] = 2'b00;
        resetn = 1'b0; stall = 1'b0; flush = 1'b0;
        set_req(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);

        // Reset state
        repeat (3) next_cyc();
        #1;
        check("rst.we",        pht_we,     0);
        check("rst.rdy0",      req0_ready, 0);
        check("rst.rdy1",      req1_ready, 0);
        check("rst.init_done", init_done,  0);
        check("rst.count",     fifo_count, 0);

        // Init sweep with requests offered; none may be taken
        next_cyc();
        resetn = 1'b1;
        set_req(1'b1, 2, 1'b1, 1'b1, 4, 1'b0);
        run_sweep("init");
        set_req(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);

        // Saturation up then down on addr 3
        single_update("t3a", 3, 1'b1, 2);
        single_update("t3b", 3, 1'b1, 3);
        single_update("t3c", 3, 1'b1, 3);
        single_update("n3a", 3, 1'b0, 2);
        single_update("n3b", 3, 1'b0, 1);
        single_update("n3c", 3, 1'b0, 0);

        // Dual push to the same address: ordered, second sees first write
        next_cyc();
        set_req(1'b1, 5, 1'b1, 1'b1, 5, 1'b0);
        #1;
        check("dual.rdy0", req0_ready, 1);
        check("dual.rdy1", req1_ready, 1);
        next_cyc();
        set_req(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
        #1;
        check("dual.count0", fifo_count, 2);
        expect_write("dual.w0", 5, 2);
        next_cyc();
        #1;
        check("dual.count1", fifo_count, 1);
        expect_write("dual.w1", 5, 1);
        next_cyc();
        #1;
        check("dual.idle_we", pht_we,     0);
        check("dual.idle_cnt", fifo_count, 0);

        // Stall while filling the queue
        stall = 1'b1;
        set_req(1'b1, 6, 1'b1, 1'b1, 7, 1'b1);
        #1;
        check("stall.rdy0a", req0_ready, 1);
        check("stall.rdy1a", req1_ready, 1);
        next_cyc();
        set_req(1'b1, 8, 1'b0, 1'b1, 9, 1'b0);
        #1;
        check("stall.cnt2",  fifo_count, 2);
        check("stall.we2",   pht_we,     0);
        check("stall.rdy0b", req0_ready, 1);
        check("stall.rdy1b", req1_ready, 1);
        next_cyc();
        set_req(1'b1, 15, 1'b1, 1'b1, 15, 1'b1);
        #1;
        check("stall.cnt4", fifo_count, 4);
        check("stall.rdy0", req0_ready, 0);
        check("stall.rdy1", req1_ready, 0);
        check("stall.we",   pht_we,     0);
        next_cyc();
        stall = 1'b0;
        set_req(1'b1, 15, 1'b1, 1'b0, 0, 1'b0);
        #1;
        check("rel.rdy0_full", req0_ready, 0);
        expect_write("rel.w6", 6, 2);
        next_cyc();
        set_req(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
        #1 expect_write("rel.w7", 7, 2);
        next_cyc();
        #1 expect_write("rel.w8", 8, 0);
        next_cyc();
        #1 expect_write("rel.w9", 9, 0);
        next_cyc();
        #1;
        check("rel.idle_we",  pht_we,     0);
        check("rel.idle_cnt", fifo_count, 0);

        // Flush with three queued updates
        stall = 1'b1;
        set_req(1'b1, 10, 1'b1, 1'b1, 11, 1'b1);
        next_cyc();
        set_req(1'b1, 12, 1'b1, 1'b0, 0, 1'b0);
        next_cyc();
        stall = 1'b0;
        flush = 1'b1;
        set_req(1'b1, 13, 1'b1, 1'b0, 0, 1'b0);
        #1;
        check("flush.cnt3", fifo_count, 3);
        check("flush.rdy0", req0_ready, 0);
        expect_write("flush.w10", 10, 2);
        next_cyc();
        flush = 1'b0;
        set_req(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
        #1;
        check("flush.cnt0", fifo_count, 0);
        check("flush.we0",  pht_we,     0);
        single_update("postflush", 14, 1'b0, 0);
        next_cyc();
        #1 check("postflush.we0", pht_we, 0);

        // Reset in the middle of the init sweep
        resetn = 1'b0;
        next_cyc();
        resetn = 1'b1;
        for (int i = 0; i < 9; i++) next_cyc();
        #1 check("rs.waddr9", pht_waddr, 9);
        resetn = 1'b0;
        next_cyc();
        #1;
        check("rs.we_rst",   pht_we,    0);
        check("rs.done_rst", init_done, 0);
        next_cyc();
        resetn = 1'b1;
        run_sweep("reinit");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
